// File: rtl/mixer_pkg.sv
// Shared constants, types and helpers for the quadrature PWM mixer.
// Imported by mixer_channel and quad_pwm_mixer.
package mixer_pkg;

    localparam int DEF_CHANNELS = 3;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_HIST_LEN = 8;
    localparam int DEF_STEP     = 1;
    localparam int DEF_FADE_DIV = 16;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    // Phase stagger of channel idx: idx * (2^width / chans)
    function automatic int unsigned phase_offset(
        input int unsigned idx,
        input int unsigned chans,
        input int unsigned width
    );
        return idx * ((32'd1 << width) / chans);
    endfunction

endpackage

// File: rtl/mixer_channel.sv
// One encoder channel: sync, debounce, decode, saturating target,
// optional fade register (MIXER_FADE_EN).
module mixer_channel
    import mixer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HIST_LEN = DEF_HIST_LEN,
    parameter int STEP     = DEF_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
`ifdef MIXER_FADE_EN
    input  logic             fade_tick,
`endif
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] duty_src
);

    localparam logic [WIDTH:0] MAX_LVL = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] STEP_W  = (WIDTH+1)'(STEP);

    logic [1:0]          a_sync;
    logic [1:0]          b_sync;
    logic [HIST_LEN-1:0] a_hist;
    logic [HIST_LEN-1:0] b_hist;
    logic                a_db;
    logic                b_db;
    logic                a_db_n;
    logic                b_db_n;
    dir_e                dir;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    target_q;
    logic [WIDTH-1:0]    target_n;

    // Two-flop synchronisers, then sample history shift registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sync <= '0;
            b_sync <= '0;
            a_hist <= '0;
            b_hist <= '0;
        end else begin
            a_sync <= {a_sync[0], enc_a};
            b_sync <= {b_sync[0], enc_b};
            a_hist <= {a_hist[HIST_LEN-2:0], a_sync[1]};
            b_hist <= {b_hist[HIST_LEN-2:0], b_sync[1]};
        end
    end

    // Debounce: switch only on a full run of equal samples
    always_comb begin
        a_db_n = a_db;
        b_db_n = b_db;
        unique case (1'b1)
            (&a_hist):  a_db_n = 1'b1;
            (~|a_hist): a_db_n = 1'b0;
            default:    a_db_n = a_db;
        endcase
        unique case (1'b1)
            (&b_hist):  b_db_n = 1'b1;
            (~|b_hist): b_db_n = 1'b0;
            default:    b_db_n = b_db;
        endcase
    end

    // Decode: only a lone A edge counts; direction from new A vs B
    always_comb begin
        dir = DIR_NONE;
        if ((a_db_n != a_db) && (b_db_n == b_db)) begin
            dir = (a_db_n != b_db) ? DIR_UP : DIR_DOWN;
        end
    end

    // Saturating step of the target level
    always_comb begin
        sum      = {1'b0, target_q} + STEP_W;
        target_n = target_q;
        unique case (dir)
            DIR_UP: begin
                target_n = (sum > MAX_LVL) ? '1 : sum[WIDTH-1:0];
            end
            DIR_DOWN: begin
                if ({1'b0, target_q} < STEP_W) begin
                    target_n = '0;
                end else begin
                    target_n = target_q - STEP_W[WIDTH-1:0];
                end
            end
            default: target_n = target_q;
        endcase
    end

    // Debounced state and target registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_db     <= 1'b0;
            b_db     <= 1'b0;
            target_q <= '0;
        end else begin
            a_db     <= a_db_n;
            b_db     <= b_db_n;
            target_q <= target_n;
        end
    end

    assign target = target_q;

`ifdef MIXER_FADE_EN
    logic [WIDTH-1:0] fade_q;

    // Fade register walks one LSB toward the target per tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            fade_q <= '0;
        end else if (fade_tick) begin
            if (fade_q < target_q) begin
                fade_q <= fade_q + 1'b1;
            end else if (fade_q > target_q) begin
                fade_q <= fade_q - 1'b1;
            end
        end
    end

    assign duty_src = fade_q;
`else
    assign duty_src = target_q;
`endif

endmodule

// File: rtl/quad_pwm_mixer.sv
// Quad encoder to phase-staggered PWM mixer, CHANNELS channels.
// Optional fade build: define MIXER_FADE_EN.
module quad_pwm_mixer
    import mixer_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HIST_LEN = DEF_HIST_LEN,
    parameter int STEP     = DEF_STEP,
    parameter int FADE_DIV = DEF_FADE_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*WIDTH-1:0] level,
    output logic                      sync
);

    logic [WIDTH-1:0] cnt;

    // Shared free-running counter; sync marks channel 0 period start
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            sync <= 1'b0;
        end else begin
            cnt  <= cnt + 1'b1;
            sync <= (cnt == '0);
        end
    end

`ifdef MIXER_FADE_EN
    logic [15:0] presc;
    logic        fade_tick;

    assign fade_tick = (presc == 16'(FADE_DIV - 1));

    // Fade prescaler: one tick every FADE_DIV clocks
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
        end else if (fade_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end
`else
    logic [31:0] fade_div_unused;
    assign fade_div_unused = 32'(FADE_DIV);
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [WIDTH-1:0] OFF =
            WIDTH'(phase_offset(i, CHANNELS, WIDTH));

        logic [WIDTH-1:0] tgt;
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] phase;
        logic [WIDTH-1:0] duty_q;
        logic [WIDTH-1:0] duty_eff;
        logic             pwm_q;

        mixer_channel #(
            .WIDTH    (WIDTH),
            .HIST_LEN (HIST_LEN),
            .STEP     (STEP)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enc_a     (enc_a[i]),
            .enc_b     (enc_b[i]),
`ifdef MIXER_FADE_EN
            .fade_tick (fade_tick),
`endif
            .target    (tgt),
            .duty_src  (src)
        );

        assign phase    = cnt + OFF;
        assign duty_eff = (phase == '0) ? src : duty_q;

        // Shadow duty loads at period start; compare is registered
        always_ff @(posedge clk) begin
            if (!reset) begin
                duty_q <= '0;
                pwm_q  <= 1'b0;
            end else begin
                duty_q <= duty_eff;
                pwm_q  <= (phase < duty_eff);
            end
        end

        assign pwm_out[i]                 = pwm_q;
        assign level[i*WIDTH +: WIDTH]    = tgt;
    end

endmodule

// File: tb/tb_quad_pwm_mixer.sv
// Self-checking bench for quad_pwm_mixer (default build).
// Random detents against a level/PWM reference model.
module tb_quad_pwm_mixer;

    localparam int CH     = 3;
    localparam int W      = 8;
    localparam int HL     = 8;
    localparam int STEP   = 1;
    localparam int FD     = 16;
    localparam int PER    = 1 << W;
    localparam int SETTLE = HL + 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [CH-1:0]   enc_a = '0;
    logic [CH-1:0]   enc_b = '0;
    logic [CH-1:0]   pwm_out;
    logic [CH*W-1:0] level;
    logic            sync;

    int n_checks = 0;
    int n_errors = 0;
    int exp_lvl [CH];
    int hi_cnt  [CH];
    int bad     [CH];
    int pos1;
    int lat;

    quad_pwm_mixer #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .HIST_LEN (HL),
        .STEP     (STEP),
        .FADE_DIV (FD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .pwm_out (pwm_out),
        .level   (level),
        .sync    (sync)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [CH*W-1:0] exp_bus();
        logic [CH*W-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[i*W +: W] = W'(exp_lvl[i]);
        return v;
    endfunction

    function automatic int offs(input int i);
        return i * (PER / CH);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Flip A; the model applies the rule new A != B -> up, else down
    task automatic toggle_a(input int ch);
        int v;
        enc_a[ch] = ~enc_a[ch];
        v = exp_lvl[ch] + ((enc_a[ch] != enc_b[ch]) ? STEP : -STEP);
        if (v > PER - 1) v = PER - 1;
        if (v < 0) v = 0;
        exp_lvl[ch] = v;
    endtask

    task automatic set_b(input int ch, input bit v);
        if (enc_b[ch] != v) begin
            enc_b[ch] = v;
            cyc(SETTLE);
        end
    endtask

    task automatic detent(input int ch, input bit up);
        set_b(ch, up ? enc_a[ch] : ~enc_a[ch]);
        toggle_a(ch);
        cyc(SETTLE);
        check("lvl", level, exp_bus());
    endtask

    task automatic goto_lvl(input int ch, input int tgt);
        while (exp_lvl[ch] != tgt) detent(ch, exp_lvl[ch] < tgt);
    endtask

    task automatic run_window(input bit poke);
        int  d [CH];
        bit  found;
        bit  e;
        for (int i = 0; i < CH; i++) begin
            d[i] = exp_lvl[i];
            hi_cnt[i] = 0;
            bad[i] = 0;
        end
        pos1 = -1;
        found = 1'b0;
        for (int k = 0; k < PER + 2 && !found; k++) begin
            @(negedge clk);
            if (sync) found = 1'b1;
        end
        check("sync_seen", found, 1);
        for (int t = 0; t < PER; t++) begin
            if (t > 0) @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                e = (((t + offs(i)) % PER) < d[i]);
                if (pwm_out[i]) hi_cnt[i]++;
                if (pwm_out[i] !== e) bad[i]++;
            end
            if (pwm_out[1] && pos1 < 0) pos1 = t;
            if (poke && t == 100) toggle_a(0);
        end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) exp_lvl[i] = 0;

        // reset held with inputs toggling
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enc_a = CH'($urandom);
            enc_b = CH'($urandom);
            @(negedge clk);
            check("rst_pwm", pwm_out, 0);
            check("rst_lvl", level, 0);
            check("rst_sync", sync, 0);
        end
        enc_a = '0;
        enc_b = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("sync_first", sync, 1);
        @(negedge clk);
        check("sync_low", sync, 0);
        lat = 0;
        for (int k = 2; k <= PER + 4 && lat == 0; k++) begin
            @(negedge clk);
            if (sync) lat = k;
        end
        check("sync_period", lat, PER);

        // latency and 10 clockwise detents on channel 1
        toggle_a(1);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (level[W +: W] != '0) lat = k;
        end
        check("latency", lat, 2 + HL + 1);
        cyc(2);
        check("lvl", level, exp_bus());
        for (int k = 0; k < 9; k++) detent(1, 1'b1);
        check("ch1_ten", level[W +: W], 10);
        check("ch0_zero", level[0 +: W], 0);
        check("ch2_zero", level[2*W +: W], 0);

        // saturation on channel 0
        for (int k = 0; k < 300; k++) begin
            detent(0, 1'b1);
            if (k == 254) check("sat_hi_at", level[0 +: W], PER - 1);
        end
        check("sat_hi_hold", level[0 +: W], PER - 1);
        for (int k = 0; k < 300; k++) begin
            detent(0, 1'b0);
            if (k == 254) check("sat_lo_at", level[0 +: W], 0);
        end
        check("sat_lo_hold", level[0 +: W], 0);

        // bounce: A toggling every 3 cycles never debounces
        for (int k = 0; k < 14; k++) begin
            enc_a[2] = ~enc_a[2];
            cyc(3);
        end
        cyc(SETTLE + 4);
        check("bounce", level, exp_bus());

        // simultaneous A and B flip is ignored
        enc_a[2] = ~enc_a[2];
        enc_b[2] = ~enc_b[2];
        cyc(SETTLE + 4);
        check("invalid", level, exp_bus());
        detent(2, 1'b1);

        // random detents with stray B moves
        for (int k = 0; k < 40; k++) begin
            int ch;
            ch = $urandom_range(0, CH - 1);
            if ($urandom_range(0, 3) == 0) set_b(ch, ~enc_b[ch]);
            detent(ch, 1'($urandom_range(0, 1)));
        end

        // duty and phase
        goto_lvl(0, 64);
        goto_lvl(1, 0);
        goto_lvl(2, PER - 1);
        set_b(0, enc_a[0]);
        cyc(2 * PER + 8);
        run_window(1'b1);
        check("hi0", hi_cnt[0], 64);
        check("hi1", hi_cnt[1], 0);
        check("hi2", hi_cnt[2], PER - 1);
        check("pat0", bad[0], 0);
        check("pat1", bad[1], 0);
        check("pat2", bad[2], 0);
        cyc(SETTLE);
        check("lvl_poke", level, exp_bus());

        goto_lvl(1, 1);
        cyc(2 * PER + 8);
        run_window(1'b0);
        check("hi0_next", hi_cnt[0], 65);
        check("hi1_one", hi_cnt[1], 1);
        check("ch1_start", pos1, PER - PER / CH);
        check("pat0b", bad[0], 0);
        check("pat1b", bad[1], 0);
        check("pat2b", bad[2], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
